interfaz_rx_tx: RTL
===================

Name: interfaz_rx_tx

Overview:
Parametrised UART-to-ALU interface, the successor to the receive-only interface. It assembles multi-byte operands A and B and an opcode from the UART receiver byte stream, presents them to the ALU with a valid pulse, and captures the ALU result. It then serialises the result byte-by-byte to the UART transmitter. A partial frame is aborted after an inactivity timeout.

Parameters:
NB_DBIT, 8, UART byte width.
NB_DATA, 8, operand/result width; must be an integer multiple of NB_DBIT (NBYTES = NB_DATA/NB_DBIT).
NB_OP, 6, opcode width; must be ≤ NB_DBIT.
TIMEOUT, 1000, idle cycles allowed between bytes of a partial frame; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_data  in  NB_DBIT  received byte from UART rx
i_done_data  in  1  one-cycle strobe, i_data valid
i_alu_result  in  NB_DATA  ALU result (combinational ALU)
i_tx_done  in  1  one-cycle strobe, UART tx finished current byte
o_a  out  NB_DATA signed  operand A
o_b  out  NB_DATA signed  operand B
o_op  out  NB_OP  opcode
o_alu_valid  out  1  one-cycle pulse, o_a/o_b/o_op updated
o_tx_data  out  NB_DBIT  byte to transmit
o_tx_start  out  1  one-cycle pulse, start UART tx
o_busy  out  1  high in EXEC/TX/TX_WAIT; rx strobes ignored
o_timeout_err  out  1  one-cycle pulse, partial frame aborted

Behaviour:
- Reset: state RX_A, byte counter 0, shadow registers 0; all outputs 0.
- States:
  - RX_A, RX_B: each i_done_data writes i_data into byte slot cnt of the shadow A/B register, LSB byte first, then cnt++. On the strobe with cnt==NBYTES-1: go to the next state, cnt=0.
  - RX_OP: on strobe, opcode = i_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
  - EXEC: lasts exactly one cycle.
  - TX, TX_WAIT: serialise the result (see below).
- Output update: for an opcode strobe in cycle N, o_a/o_b/o_op load together from the shadow registers and o_alu_valid=1 in cycle N+1 (EXEC). The outputs hold between frames and are never partially updated.
- Result capture: i_alu_result is sampled at the clock edge ending EXEC into the tx shift register; byte index resets to 0.
- TX: one-cycle state with o_tx_start=1 and o_tx_data = current byte (LSB first). Then go to TX_WAIT.
- TX_WAIT: on i_tx_done, shift to the next byte. If bytes remain, return to TX; after the last byte, return to RX_A. o_tx_data holds its value until the next TX.
- Ignored inputs: i_done_data in EXEC/TX/TX_WAIT; i_tx_done outside TX_WAIT.
- Timeout counter:
  - Active only in RX_A with cnt>0, and in RX_B and RX_OP. Cleared on every accepted strobe.
  - Strobe in cycle S with no further strobe: the strobe in cycle S+TIMEOUT is still accepted.
  - Otherwise o_timeout_err=1 in cycle S+TIMEOUT+1; state returns to RX_A, cnt=0, shadow data discarded. o_a/o_b/o_op are unchanged.
  - A strobe in the same cycle as expiry wins and no error is raised.
  - No timeout in TX_WAIT.
- Signedness: o_a/o_b are two's complement at NB_DATA; no extension or truncation.
- Reset mid-frame or mid-transmission: the next cycle is full reset state; any pending tx byte is dropped and o_tx_start stays 0.

Test Plan:
1. Defaults, reset then strobes 0x04, 0x02, 0x08 → one cycle after the third strobe: o_a=4, o_b=2, o_op=0x08, o_alu_valid high exactly 1 cycle. With i_alu_result=0x06: next cycle o_tx_start=1, o_tx_data=0x06, o_busy=1. i_tx_done → o_busy=0, back to RX_A.
2. Strobes 0xFC, 0x03, 0x01 → o_a = −4 (signed), o_b=3, o_op=1. Strobe op 0xFF with NB_OP=6 → o_op=0x3F.
3. NB_DATA=16: strobes 0x34, 0x12, 0xCD, 0xAB, op 0x20 → o_a=0x1234, o_b=0xABCD. With i_alu_result=0x5678: tx 0x78, then after i_tx_done tx 0x56, then idle.
4. TIMEOUT=20: one strobe 0x11, then 20 idle cycles → o_timeout_err pulse on cycle 21, outputs unchanged. Next 0x01, 0x02, 0x03 → o_a=1, o_b=2, o_op=3. Repeat with a strobe on idle cycle 20 → no error.
5. Strobes 0x05 and 0x07 during TX_WAIT → ignored; the subsequent frame 0x01, 0x01, 0x02 decodes correctly. An i_tx_done pulse during RX_B → no effect.
6. Assert i_rst after the second byte, and again during TX_WAIT → all outputs 0 next cycle, no o_tx_start. A fresh frame decodes correctly.

Source files
------------

// File: rtl/interfaz_rx_tx.sv
// interfaz_rx_tx
// Takes a byte stream from a UART receiver and builds frames of the form
// A (NBYTES bytes, LSB first), B (NBYTES bytes, LSB first), opcode (1 byte).
// It presents the operands to a combinational ALU with a one-cycle valid pulse.
// It captures the ALU result and sends it back to the UART transmitter one
// byte at a time, LSB first.
// If a frame stalls for more than TIMEOUT cycles, the partial frame is dropped.
//
// Ports
//   i_clk, i_rst     clock and synchronous active-high reset
//   i_data           received byte, qualified by the i_done_data strobe
//   i_alu_result     result of the external ALU
//   i_tx_done        strobe from the transmitter: current byte has been sent
//   o_a, o_b, o_op   operands and opcode; all three update together
//   o_alu_valid      one-cycle pulse when o_a/o_b/o_op take new values
//   o_tx_data        byte to transmit, held between transmissions
//   o_tx_start       one-cycle pulse that starts the transmitter
//   o_busy           high while executing or transmitting (rx strobes ignored)
//   o_timeout_err    one-cycle pulse when a partial frame is dropped
module interfaz_rx_tx #(
  parameter int NB_DBIT = 8,
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NB_DBIT-1:0]        i_data,
  input  logic                      i_done_data,
  input  logic [NB_DATA-1:0]        i_alu_result,
  input  logic                      i_tx_done,
  output logic signed [NB_DATA-1:0] o_a,
  output logic signed [NB_DATA-1:0] o_b,
  output logic [NB_OP-1:0]          o_op,
  output logic                      o_alu_valid,
  output logic [NB_DBIT-1:0]        o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  localparam int NBYTES = NB_DATA / NB_DBIT;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  // The idle timer never needs to hold more than TIMEOUT-1.
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMR_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX, TX_WAIT} state_t;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              cnt_reg;
  logic [CW-1:0]              tx_idx_reg;
  logic [TW-1:0]              tmr_reg;
  logic [NB_DATA-1:0]         shadow_a_reg, shadow_b_reg;
  logic [NB_DATA-1:0]         shadow_a_next, shadow_b_next;
  logic [NB_DATA-1:0]         tx_shift_reg;
  logic signed [NB_DATA-1:0]  a_reg, b_reg;
  logic [NB_OP-1:0]           op_reg;
  logic                       timeout_err_reg;

  logic rx_state, rx_active, accept, last_byte, tx_last, expire;
  logic wr_a, wr_b;

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    rx_state   = (state_reg == RX_A) || (state_reg == RX_B) || (state_reg == RX_OP);
    // The timer only runs once a frame has actually started.
    rx_active  = ((state_reg == RX_A) && (cnt_reg != '0)) ||
                 (state_reg == RX_B) || (state_reg == RX_OP);
    accept     = rx_state && i_done_data;
    last_byte  = (cnt_reg == CNT_LAST);
    tx_last    = (tx_idx_reg == CNT_LAST);
    // A strobe arriving in the expiry cycle takes priority over the abort.
    expire     = (TIMEOUT != 0) && rx_active && !i_done_data && (tmr_reg == TMR_LAST);
    wr_a       = accept && (state_reg == RX_A);
    wr_b       = accept && (state_reg == RX_B);

    case (state_reg)
      RX_A: begin
        if (accept && last_byte) state_next = RX_B;
        else if (expire)         state_next = RX_A;
      end
      RX_B: begin
        if (accept && last_byte) state_next = RX_OP;
        else if (expire)         state_next = RX_A;
      end
      RX_OP: begin
        if (accept)      state_next = EXEC;
        else if (expire) state_next = RX_A;
      end
      EXEC:    state_next = TX;
      TX:      state_next = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) state_next = tx_last ? RX_A : TX;
      end
      default: state_next = RX_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= RX_A;
    else       state_reg <= state_next;
  end

  // Write the byte at slot cnt of the shadow register that is being filled.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
    assign shadow_a_next[gi*NB_DBIT +: NB_DBIT] =
      (wr_a && (cnt_reg == CW'(gi))) ? i_data : shadow_a_reg[gi*NB_DBIT +: NB_DBIT];
    assign shadow_b_next[gi*NB_DBIT +: NB_DBIT] =
      (wr_b && (cnt_reg == CW'(gi))) ? i_data : shadow_b_reg[gi*NB_DBIT +: NB_DBIT];
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg         <= '0;
      tx_idx_reg      <= '0;
      tmr_reg         <= '0;
      shadow_a_reg    <= '0;
      shadow_b_reg    <= '0;
      tx_shift_reg    <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      op_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= expire;

      if (!rx_active || i_done_data) tmr_reg <= '0;
      else                           tmr_reg <= tmr_reg + 1'b1;

      if (expire) begin
        cnt_reg      <= '0;
        shadow_a_reg <= '0;
        shadow_b_reg <= '0;
      end else begin
        shadow_a_reg <= shadow_a_next;
        shadow_b_reg <= shadow_b_next;
        if (wr_a || wr_b) cnt_reg <= last_byte ? '0 : cnt_reg + 1'b1;
      end

      // The opcode strobe publishes the whole frame at once.
      if (accept && (state_reg == RX_OP)) begin
        a_reg  <= shadow_a_reg;
        b_reg  <= shadow_b_reg;
        op_reg <= i_data[NB_OP-1:0];
      end

      if (state_reg == EXEC) begin
        tx_shift_reg <= i_alu_result;
        tx_idx_reg   <= '0;
      end else if ((state_reg == TX_WAIT) && i_tx_done && !tx_last) begin
        // Do not shift after the last byte, so o_tx_data keeps that byte.
        tx_shift_reg <= tx_shift_reg >> NB_DBIT;
        tx_idx_reg   <= tx_idx_reg + 1'b1;
      end
    end
  end

  assign o_a           = a_reg;
  assign o_b           = b_reg;
  assign o_op          = op_reg;
  assign o_alu_valid   = (state_reg == EXEC);
  assign o_tx_start    = (state_reg == TX);
  assign o_busy        = (state_reg == EXEC) || (state_reg == TX) || (state_reg == TX_WAIT);
  assign o_tx_data     = tx_shift_reg[NB_DBIT-1:0];
  assign o_timeout_err = timeout_err_reg;

endmodule
